// File: rtl/lane_tick_scheduler_pkg.sv
// Shared types and constants for the lane movement scheduler.
// Lane i steps once every LANE_PERIOD[i] base ticks at difficulty stage 0.
package lane_tick_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } run_state_t;

    localparam int MAX_LANES = 4;
    localparam int LANE_PERIOD [MAX_LANES] = '{4, 3, 4, 2};

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max_lane_period();
        int m;
        m = 1;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (LANE_PERIOD[i] > m) m = LANE_PERIOD[i];
        end
        return m;
    endfunction

    // Lane counters only ever hold 0..period-1, so the largest period bounds them.
    localparam int LANE_CW = (clog2(max_lane_period() + 1) < 1) ? 1 : clog2(max_lane_period() + 1);

endpackage

// File: rtl/lane_tick_scheduler_lane_divider.sv
// Per-lane divider: counts base-tick wraps and emits a one-cycle step pulse
// every `period` wraps. Clear or disable forces the count back to zero.
module lane_divider
    import lane_tick_scheduler_pkg::*;
#(
    parameter int CNT_W = LANE_CW
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             adv,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_p0;

    // Count/wrap stage; tick is registered alongside the counter wrap.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            cnt_p0 <= '0;
            tick   <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clr || !en) begin
                cnt_p0 <= '0;
            end else if (adv) begin
                if (cnt_p0 >= period - CNT_W'(1)) begin
                    cnt_p0 <= '0;
                    tick   <= 1'b1;
                end else begin
                    cnt_p0 <= cnt_p0 + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/lane_tick_scheduler.sv
// Shared movement scheduler: game-run FSM, base prescaler, difficulty stage and
// one divider per lane producing registered move_tick step enables.
module lane_tick_scheduler
    import lane_tick_scheduler_pkg::*;
#(
    parameter int NLANES   = 4,
    parameter int BASE_DIV = 250000,
    parameter int CW       = 22,
    parameter int NSTAGES  = 4,
    localparam int SW      = (clog2(NSTAGES) < 1) ? 1 : clog2(NSTAGES)
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              pause_req,
    input  logic              level_up,
    input  logic [NLANES-1:0] lane_en,
    output logic [NLANES-1:0] move_tick,
    output logic              base_tick,
    output logic [SW-1:0]     stage,
    output logic              running
);

    localparam logic [SW-1:0] STAGE_MAX = SW'(NSTAGES - 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(BASE_DIV - 1);

    run_state_t      state;
    logic            rst_meta;
    logic            rst_sync;
    logic [CW-1:0]   pre_cnt_p0;
    logic            wrap_p0;
    logic            lvl_acc;
    logic            adv_p0;

    function automatic logic [LANE_CW-1:0] p_eff(input int base, input logic [SW-1:0] st);
        logic [LANE_CW-1:0] v;
        v = LANE_CW'(base) >> st;
        return (v == '0) ? LANE_CW'(1) : v;
    endfunction

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            rst_meta <= 1'b1;
            rst_sync <= 1'b1;
        end else begin
            rst_meta <= 1'b0;
            rst_sync <= rst_meta;
        end
    end

    assign wrap_p0 = (state == RUN) && (pre_cnt_p0 == PRE_LAST);
    assign lvl_acc = level_up && (state != IDLE);
    // A level_up restart swallows any wrap landing on the same edge.
    assign adv_p0  = wrap_p0 && !lvl_acc;

    // Control stage: FSM, prescaler, difficulty stage and base_tick register.
    always_ff @(posedge frame_clk or posedge rst_sync) begin
        if (rst_sync) begin
            state      <= IDLE;
            running    <= 1'b0;
            pre_cnt_p0 <= '0;
            stage      <= '0;
            base_tick  <= 1'b0;
        end else begin
            base_tick <= adv_p0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (pause_req) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (!pause_req) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase

            if (lvl_acc) begin
                pre_cnt_p0 <= '0;
            end else if (state == RUN) begin
                pre_cnt_p0 <= wrap_p0 ? '0 : pre_cnt_p0 + CW'(1);
            end

            if (lvl_acc && (stage != STAGE_MAX)) begin
                stage <= stage + SW'(1);
            end
        end
    end

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        lane_divider #(
            .CNT_W(LANE_CW)
        ) u_div (
            .frame_clk(frame_clk),
            .Reset    (rst_sync),
            .adv      (adv_p0),
            .clr      (lvl_acc),
            .en       (lane_en[i]),
            .period   (p_eff(LANE_PERIOD[i], stage)),
            .tick     (move_tick[i])
        );
    end

endmodule

// File: tb/tb_lane_tick_scheduler.sv
// Directed bench for lane_tick_scheduler with BASE_DIV=4 and periods {4,3,4,2}.
module tb_lane_tick_scheduler;

    logic       frame_clk;
    logic       Reset;
    logic       start;
    logic       pause_req;
    logic       level_up;
    logic [3:0] lane_en;
    logic [3:0] move_tick;
    logic       base_tick;
    logic [1:0] stage;
    logic       running;

    int checks;
    int errors;

    lane_tick_scheduler #(
        .NLANES  (4),
        .BASE_DIV(4),
        .CW      (3),
        .NSTAGES (4)
    ) dut (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .start    (start),
        .pause_req(pause_req),
        .level_up (level_up),
        .lane_en  (lane_en),
        .move_tick(move_tick),
        .base_tick(base_tick),
        .stage    (stage),
        .running  (running)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) cyc();
        Reset = 1'b0;
        repeat (3) cyc();
    endtask

    // Drive start so it is sampled by the next edge (E0); returns at the negedge after E0.
    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    logic [3:0] exp_mt;
    logic       exp_bt;
    logic [1:0] exp_st;
    logic       exp_run;

    initial begin
        checks    = 0;
        errors    = 0;
        Reset     = 1'b1;
        start     = 1'b0;
        pause_req = 1'b0;
        level_up  = 1'b0;
        lane_en   = 4'b1111;
        @(negedge frame_clk);
        cyc();

        chk("rst_move_tick", move_tick, 4'b0000);
        chk("rst_base_tick", base_tick, 1'b0);
        chk("rst_running", running, 1'b0);
        chk("rst_stage", stage, 2'd0);

        // Scenario A: first-tick latency at stage 0
        do_reset();
        level_up = 1'b1;
        cyc();
        level_up = 1'b0;
        chk("idle_level_up_stage", stage, 2'd0);
        do_start();
        chk("A_running", running, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            exp_mt = (k == 8) ? 4'b1000 : (k == 12) ? 4'b0010 : (k == 16) ? 4'b1101 : 4'b0000;
            exp_bt = (k % 4 == 0);
            chk($sformatf("A_mt_e%0d", k), move_tick, exp_mt);
            chk($sformatf("A_bt_e%0d", k), base_tick, exp_bt);
        end

        // Scenario B: pause sampled at E6..E15 freezes the count
        do_reset();
        do_start();
        for (int k = 1; k <= 20; k++) begin
            pause_req = (k >= 6 && k <= 15);
            cyc();
            exp_mt  = (k == 18) ? 4'b1000 : 4'b0000;
            exp_bt  = (k == 4 || k == 18);
            exp_run = (k < 6 || k >= 16);
            chk($sformatf("B_mt_e%0d", k), move_tick, exp_mt);
            chk($sformatf("B_bt_e%0d", k), base_tick, exp_bt);
            chk($sformatf("B_run_e%0d", k), running, exp_run);
        end
        pause_req = 1'b0;

        // Scenario C/D: two level_ups then five more, saturating at stage 3
        do_reset();
        do_start();
        for (int k = 1; k <= 23; k++) begin
            level_up = (k == 1 || k == 2 || (k >= 15 && k <= 19));
            cyc();
            exp_st = (k == 1) ? 2'd1 : (k < 15) ? 2'd2 : 2'd3;
            exp_mt = (k == 6 || k == 10 || k == 14 || k == 23) ? 4'b1111 : 4'b0000;
            exp_bt = (k == 6 || k == 10 || k == 14 || k == 23);
            chk($sformatf("C_stage_e%0d", k), stage, exp_st);
            chk($sformatf("C_mt_e%0d", k), move_tick, exp_mt);
            chk($sformatf("C_bt_e%0d", k), base_tick, exp_bt);
        end
        level_up = 1'b0;

        // Scenario F: asynchronous reset between edges while outputs are active
        #2;
        Reset = 1'b1;
        #1;
        chk("F_async_mt", move_tick, 4'b0000);
        chk("F_async_bt", base_tick, 1'b0);
        chk("F_async_run", running, 1'b0);
        chk("F_async_stage", stage, 2'd0);
        @(negedge frame_clk);
        cyc();
        Reset = 1'b0;
        repeat (3) cyc();
        level_up = 1'b1;
        cyc();
        level_up = 1'b0;
        chk("F_idle_stage", stage, 2'd0);
        chk("F_idle_run", running, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk($sformatf("F_idle_mt_%0d", k), move_tick, 4'b0000);
        end

        // Scenario E: lane 1 disabled across the E8 wrap, then re-enabled
        do_reset();
        do_start();
        for (int k = 1; k <= 20; k++) begin
            lane_en = (k == 7 || k == 8) ? 4'b1101 : 4'b1111;
            cyc();
            exp_mt = (k == 8) ? 4'b1000 : (k == 16) ? 4'b1101 : (k == 20) ? 4'b0010 : 4'b0000;
            chk($sformatf("E_mt_e%0d", k), move_tick, exp_mt);
        end
        lane_en = 4'b1111;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
